mole_level_controller: RTL
==========================

# mole_level_controller

Game sequencer for the three-mole whack-a-mole datapath. Owns the `game` enable that gates the mole display controller and player scorer, and runs a fixed-length round timer. Counts successful hits, raises the difficulty level every `HITS_PER_LEVEL` hits, and supplies the 28-bit `speed` reload value for the mole rate counter, replacing the manual speed input.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per round-timer second.
- `ROUND_SECONDS`, default 30: round length in seconds; legal range 1..63.
- `HITS_PER_LEVEL`, default 5: hits needed per level step; legal range 1..15.
- `SPEED_L0`, default 28'd50_000_000: rate-counter reload at level 0.
- `SPEED_STEP`, default 28'd10_000_000: reload decrement per level; must satisfy `SPEED_L0 > 3*SPEED_STEP`.
- `clock` in 1: single clock; every flop is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: player start button, level signal; only its rising edge is used.
- `hit` in 1: one-cycle pulse per successful whack, from the player scorer's turnoff.
- `game` out 1: high only in PLAY; drives the display controller and player `game` inputs.
- `speed` out 28: current rate-counter reload value.
- `level` out 2: current level, 0..3.
- `level_up` out 1: one-cycle pulse on the cycle `level` increments.
- `score` out 8: hits this round, saturating at 255.
- `time_left` out 6: seconds remaining in the round.
- `game_over` out 1: high in OVER.

## Operation
- Internal `start_q` flop; `start_rise = start & ~start_q`. `start_q` clears on reset.
- States: IDLE, ARM, PLAY, OVER. All outputs are registered or decoded from the state flop; there are no combinational paths from inputs to outputs.
- IDLE:
  - `start_rise` → ARM.
- ARM (exactly one cycle, `game` = 0, so the random generator loads its seed):
  - Load `time_left` = ROUND_SECONDS, prescaler = TICKS_PER_SEC-1.
  - Clear `level`, `score` and `hit_cnt`; set `speed` = SPEED_L0.
  - Go to PLAY.
- PLAY, every cycle:
  - If prescaler = 0: reload it to TICKS_PER_SEC-1 and generate `sec_tick`; otherwise decrement it.
  - On `sec_tick`, `time_left` decrements. If `sec_tick` occurs with `time_left` = 1, the next state is OVER and `time_left` becomes 0.
- Hit handling (only when the state is PLAY at the edge; `hit` is ignored in all other states):
  - `score` increments, saturating at 255.
  - If `hit_cnt` = HITS_PER_LEVEL-1 and `level` < 3: `level` increments, `hit_cnt` clears, `level_up` = 1 and `speed` is reduced by SPEED_STEP, all on the same edge.
  - Otherwise, if `level` = 3: `hit_cnt` holds at 0 and there are no further level changes.
  - Otherwise: `hit_cnt` increments.
- Speed is always `SPEED_L0 - level*SPEED_STEP`, computed in 28 bits with no wrap, guaranteed by the parameter constraint.
- OVER:
  - `game_over` = 1.
  - `score`, `level` and `speed` hold their final values.
  - `start_rise` → ARM, which begins a new round.
- `start_rise` in ARM or PLAY is ignored.

## Timing
- Reset values: state IDLE, `game` 0, `game_over` 0, `speed` SPEED_L0, `level` 0, `level_up` 0, `score` 0, `time_left` 0, prescaler 0, `hit_cnt` 0.
- Reset has priority over every other event and takes effect on the edge where it is sampled, including mid-round. The cycle after reset shows all reset values.
- Start sequence: `start` rises and is sampled at edge N in IDLE. After N, state is ARM. After N+1, state is PLAY, `game` = 1 and `time_left` = ROUND_SECONDS.
- `game` stays high for exactly ROUND_SECONDS*TICKS_PER_SEC cycles.
- `time_left` first decrements on the TICKS_PER_SEC-th PLAY edge.
- A `hit` on the final PLAY edge (the same edge that enters OVER) is counted.
- `hit` coinciding with `sec_tick`: both take effect.
- `level_up` is never asserted outside PLAY.

## Test plan
All scenarios use TICKS_PER_SEC=4, ROUND_SECONDS=3, HITS_PER_LEVEL=2, SPEED_L0=100, SPEED_STEP=20.
- Reset then idle: hold `start` low for 20 cycles → `game` 0, `speed` 100, `time_left` 0, `game_over` 0 throughout.
- Start pulse → one ARM cycle with `game` 0, then `game` high for exactly 12 cycles. `time_left` steps 3→2→1→0 every 4 cycles. Then `game_over` 1. Holding `start` high through the round causes no restart.
- 7 hits spaced 1 cycle apart from PLAY start → `level` 0→1→2→3 after hits 2, 4 and 6, each with a one-cycle `level_up`. `speed` steps 100→80→60→40. `score` = 7 and `level` stays 3.
- `hit` asserted on the final PLAY edge and again in OVER → only the first is counted; `score` = 1.
- Assert `reset` at PLAY cycle 6 with `score` 2 and `level` 1 → next cycle shows IDLE with every output at its reset value.
- From OVER with `score` 5, new `start` edge → ARM clears `score` to 0, `level` to 0 and `speed` to 100, and `game_over` drops.

Source files
------------

// File: rtl/mole_level_controller_if.sv
// mole_level_controller_if
// Groups the game-sequencer signals into one bundle.
//   start     : player start button (level signal)
//   hit       : one-cycle pulse per successful whack
//   game      : high while a round is being played
//   speed     : 28-bit rate-counter reload value
//   level     : current difficulty level 0..3
//   level_up  : one-cycle pulse when level increments
//   score     : hits this round, saturating at 255
//   time_left : seconds remaining in the round
//   game_over : high once the round has ended
// The slave modport is the controller; master is the surrounding logic.
interface mole_level_controller_if;
    logic        start;
    logic        hit;
    logic        game;
    logic [27:0] speed;
    logic [1:0]  level;
    logic        level_up;
    logic [7:0]  score;
    logic [5:0]  time_left;
    logic        game_over;

    modport slave (
        input  start, hit,
        output game, speed, level, level_up, score, time_left, game_over
    );

    modport master (
        output start, hit,
        input  game, speed, level, level_up, score, time_left, game_over
    );
endinterface

// File: rtl/mole_level_controller.sv
// mole_level_controller
// Round sequencer for the whack-a-mole datapath: IDLE -> ARM -> PLAY -> OVER.
// Runs a seconds timer during PLAY, counts hits, raises the level every
// HITS_PER_LEVEL hits (up to 3) and supplies the mole rate reload value.
// Ports:
//   clock : single rising-edge clock
//   reset : synchronous, active-high
//   bus   : mole_level_controller_if.slave (start/hit in, status out)
module mole_level_controller #(
    parameter int          TICKS_PER_SEC  = 50_000_000,
    parameter int          ROUND_SECONDS  = 30,
    parameter int          HITS_PER_LEVEL = 5,
    parameter logic [27:0] SPEED_L0       = 28'd50_000_000,
    parameter logic [27:0] SPEED_STEP     = 28'd10_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    mole_level_controller_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [5:0]    ROUND_LEN = 6'(ROUND_SECONDS);
    localparam logic [3:0]    HIT_LAST  = 4'(HITS_PER_LEVEL - 1);

    typedef enum logic [1:0] {IDLE, ARM, PLAY, OVER} state_t;

    state_t        state_reg;
    logic          start_q_reg;
    logic [PW-1:0] presc_reg;
    logic [5:0]    time_left_reg;
    logic [1:0]    level_reg;
    logic          level_up_reg;
    logic [7:0]    score_reg;
    logic [3:0]    hit_cnt_reg;
    logic [27:0]   speed_reg;

    logic start_rise;
    logic sec_tick;
    logic round_end;
    logic hit_take;
    logic level_inc;

    always_comb begin
        start_rise = bus.start & ~start_q_reg;
        sec_tick   = (state_reg == PLAY) && (presc_reg == '0);
        round_end  = sec_tick && (time_left_reg == 6'd1);
        hit_take   = (state_reg == PLAY) && bus.hit;
        level_inc  = hit_take && (hit_cnt_reg == HIT_LAST) && (level_reg != 2'd3);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            start_q_reg   <= 1'b0;
            presc_reg     <= '0;
            time_left_reg <= '0;
            level_reg     <= '0;
            level_up_reg  <= 1'b0;
            score_reg     <= '0;
            hit_cnt_reg   <= '0;
            speed_reg     <= SPEED_L0;
        end else begin
            start_q_reg  <= bus.start;
            level_up_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_rise) state_reg <= ARM;
                end
                ARM: begin
                    time_left_reg <= ROUND_LEN;
                    presc_reg     <= TICK_LAST;
                    level_reg     <= '0;
                    score_reg     <= '0;
                    hit_cnt_reg   <= '0;
                    speed_reg     <= SPEED_L0;
                    state_reg     <= PLAY;
                end
                PLAY: begin
                    if (sec_tick) begin
                        presc_reg     <= TICK_LAST;
                        time_left_reg <= time_left_reg - 6'd1;
                    end else begin
                        presc_reg <= presc_reg - 1'b1;
                    end
                    if (round_end) state_reg <= OVER;

                    if (hit_take) begin
                        if (score_reg != 8'hFF) score_reg <= score_reg + 8'd1;
                        if (level_inc) begin
                            level_reg    <= level_reg + 2'd1;
                            hit_cnt_reg  <= '0;
                            speed_reg    <= speed_reg - SPEED_STEP;
                            // The level still advances on the final edge, but the
                            // pulse would land in OVER, so it is suppressed there.
                            level_up_reg <= ~round_end;
                        end else if (level_reg == 2'd3) begin
                            hit_cnt_reg <= '0;
                        end else begin
                            hit_cnt_reg <= hit_cnt_reg + 4'd1;
                        end
                    end
                end
                OVER: begin
                    if (start_rise) state_reg <= ARM;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.game      = (state_reg == PLAY);
    assign bus.game_over = (state_reg == OVER);
    assign bus.speed     = speed_reg;
    assign bus.level     = level_reg;
    assign bus.level_up  = level_up_reg;
    assign bus.score     = score_reg;
    assign bus.time_left = time_left_reg;

endmodule
